phys_reg_free_list: RTL and testbench



---
 rtl/phys_reg_free_list_if.sv | 27 ++
 rtl/phys_reg_free_list.sv | 95 +++++++++
 tb/tb_phys_reg_free_list.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename-side bundle of the physical-register free list: allocation, ROB commit/recovery
// and the committed-map restore stream toward the speculative RAT.
interface phys_reg_free_list_if;
  logic       alloc_req;
  logic       alloc_ready;
  logic [6:0] alloc_preg;
  logic       commit_wb_en;
  logic [6:0] commit_P_rd_old;
  logic [6:0] commit_P_rd_new;
  logic [5:0] commit_A_rd;
  logic       recovery;
  logic       restore_valid;
  logic [5:0] restore_A_rd;
  logic [6:0] restore_P_rd;
  logic       busy;
  logic [6:0] free_count;

  modport master (
    output alloc_req, commit_wb_en, commit_P_rd_old, commit_P_rd_new, commit_A_rd, recovery,
    input  alloc_ready, alloc_preg, restore_valid, restore_A_rd, restore_P_rd, busy, free_count
  );

  modport slave (
    input  alloc_req, commit_wb_en, commit_P_rd_old, commit_P_rd_new, commit_A_rd, recovery,
    output alloc_ready, alloc_preg, restore_valid, restore_A_rd, restore_P_rd, busy, free_count
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Physical-register free FIFO plus committed arch->phys map; rolls back speculative
// allocations on ROB recovery and streams the committed map out one register per cycle.
module phys_reg_free_list #(
  parameter int NUM_PREG = 128,
  parameter int NUM_AREG = 64
) (
  input logic               clk,
  input logic               rst,
  phys_reg_free_list_if.slave fl
);
  localparam int PW    = $clog2(NUM_PREG);
  localparam int AW    = $clog2(NUM_AREG);
  localparam int DEPTH = NUM_PREG - NUM_AREG;
  localparam int IW    = $clog2(DEPTH);
  localparam int PTR_W = IW + 1;

  typedef enum logic {IDLE, RESTORE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [PTR_W-1:0] head_q, head_d, chead_q, chead_d, tail_q, tail_d;
  logic [PW-1:0]    fifo_q [DEPTH];
  logic [PW-1:0]    rat_q  [NUM_AREG];

  logic empty, push, cmt_new, grant, start;

  assign empty   = (head_q == tail_q);
  assign push    = fl.commit_wb_en && (fl.commit_P_rd_old != '0);
  assign cmt_new = fl.commit_wb_en && (fl.commit_P_rd_new != '0);

  assign fl.alloc_preg = fifo_q[head_q[IW-1:0]];
  assign fl.free_count = PW'(tail_q - head_q);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    start            = 1'b0;
    fl.alloc_ready   = 1'b0;
    fl.busy          = 1'b0;
    fl.restore_valid = 1'b0;
    fl.restore_A_rd  = '0;
    fl.restore_P_rd  = '0;
    unique case (state_q)
      IDLE: begin
        fl.alloc_ready = !empty;
        if (fl.recovery) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = RESTORE;
        end
      end
      RESTORE: begin
        fl.busy          = 1'b1;
        fl.restore_valid = 1'b1;
        fl.restore_A_rd  = idx_q;
        fl.restore_P_rd  = rat_q[idx_q];
        idx_d            = idx_q + 1'b1;
        if (idx_q == '1) state_d = IDLE;
        // A fresh recovery restarts the walk from arch register 0.
        if (fl.recovery) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = RESTORE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Allocation in the recovery cycle is discarded; head snaps to the committed pointer.
  assign grant   = fl.alloc_req && fl.alloc_ready && !fl.recovery;
  assign chead_d = chead_q + PTR_W'(cmt_new);
  assign tail_d  = tail_q + PTR_W'(push);
  assign head_d  = start ? chead_d : head_q + PTR_W'(grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= PW'(NUM_AREG + i);
      for (int i = 0; i < NUM_AREG; i++) rat_q[i] <= PW'(i);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      if (push)    fifo_q[tail_q[IW-1:0]] <= fl.commit_P_rd_old;
      if (cmt_new) rat_q[fl.commit_A_rd]  <= fl.commit_P_rd_new;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a queue-level model of
// free pregs, in-flight renames and the committed map.
module tb_phys_reg_free_list;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if bus();
  phys_reg_free_list #(.NUM_PREG(128), .NUM_AREG(64)) dut (.clk(clk), .rst(rst), .fl(bus));

  typedef struct { int rd; int newp; int oldp; } inst_t;

  int    freeq[$];
  inst_t infl[$];
  int    rat[64];
  int    srat[64];
  bit    owned[128];
  int    rcnt;
  int    n_cmp = 0;
  int    n_err = 0;
  int    busy_cnt = 0;
  bit    last_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    freeq.delete();
    infl.delete();
    for (int i = 0; i < 64; i++) freeq.push_back(64 + i);
    for (int i = 0; i < 64; i++) begin rat[i] = i; srat[i] = i; end
    for (int i = 0; i < 128; i++) owned[i] = (i < 64);
    rcnt = -1;
  endfunction

  task automatic idle_inputs();
    bus.alloc_req       = 1'b0;
    bus.commit_wb_en    = 1'b0;
    bus.commit_P_rd_old = '0;
    bus.commit_P_rd_new = '0;
    bus.commit_A_rd     = '0;
    bus.recovery        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_free_count"}, bus.free_count, 64);
    chk({tag, "_alloc_preg"}, bus.alloc_preg, 64);
    chk({tag, "_alloc_ready"}, bus.alloc_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_restore_valid"}, bus.restore_valid, 0);
  endtask

  // cmt: 0 none, 1 commit oldest in-flight rename, 2 commit with all-zero fields
  task automatic cycle(input bit req, input int rd, input int cmt, input bit rec);
    inst_t c;
    bit    do_c;
    bit    ready;
    int    g;
    int    dp;
    c    = '{0, 0, 0};
    do_c = (cmt == 1) && (infl.size() > 0);
    if (do_c) c = infl.pop_front();
    bus.alloc_req       = req;
    bus.recovery        = rec;
    bus.commit_wb_en    = do_c || (cmt == 2);
    bus.commit_A_rd     = 6'(c.rd);
    bus.commit_P_rd_new = 7'(c.newp);
    bus.commit_P_rd_old = 7'(c.oldp);
    @(negedge clk);
    ready = (rcnt < 0) && (freeq.size() > 0);
    dp    = int'(bus.alloc_preg);
    chk("alloc_ready", bus.alloc_ready, ready);
    chk("busy", bus.busy, rcnt >= 0);
    chk("restore_valid", bus.restore_valid, rcnt >= 0);
    chk("free_count", bus.free_count, freeq.size());
    if (ready) chk("alloc_preg", bus.alloc_preg, freeq[0]);
    chk("restore_A_rd", bus.restore_A_rd, (rcnt >= 0) ? rcnt : 0);
    chk("restore_P_rd", bus.restore_P_rd, (rcnt >= 0) ? rat[rcnt] : 0);
    if (do_c && c.oldp != 0) chk("no_overflow", bus.free_count < 7'd64, 1);
    if (bus.busy === 1'b1) busy_cnt++;
    @(posedge clk);
    last_grant = 1'b0;
    if (do_c) begin
      rat[c.rd] = c.newp;
      freeq.push_back(c.oldp);
      owned[c.oldp] = 1'b0;
    end
    if (req && ready && !rec) begin
      g = freeq.pop_front();
      chk("dup_alloc", owned[dp & 127], 0);
      owned[g] = 1'b1;
      infl.push_back('{rd, g, srat[rd]});
      srat[rd]   = g;
      last_grant = 1'b1;
    end
    if (rec) begin
      for (int i = infl.size() - 1; i >= 0; i--) begin
        freeq.push_front(infl[i].newp);
        owned[infl[i].newp] = 1'b0;
      end
      infl.delete();
      srat = rat;
      rcnt = 0;
    end else if (rcnt >= 0) begin
      rcnt = (rcnt == 63) ? -1 : rcnt + 1;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, committed, guard, cm;
    bit req;
    do_reset();
    chk_reset_state("reset");

    // Drain: 64 grants in order, then empty; the 65th request is dropped.
    for (int i = 0; i < 64; i++) cycle(1'b1, 1 + (i % 63), 0, 1'b0);
    chk("drain_ready", bus.alloc_ready, 0);
    chk("drain_count", bus.free_count, 0);
    cycle(1'b1, 7, 0, 1'b0);
    chk("drop_count", bus.free_count, 0);

    // Empty list with same-cycle free: not allocatable until next cycle.
    cycle(1'b1, 9, 1, 1'b0);
    chk("edge_ready_next", bus.alloc_ready, 1);
    chk("edge_preg_next", bus.alloc_preg, 1);
    while (infl.size() > 0) cycle(1'b0, 0, 1, 1'b0);
    chk("refill_count", bus.free_count, 64);

    // Commit reclaim.
    do_reset();
    cycle(1'b1, 5, 0, 1'b0);
    chk("reclaim_before", bus.free_count, 63);
    cycle(1'b0, 0, 1, 1'b0);
    chk("reclaim_after", bus.free_count, 64);
    for (int i = 0; i < 63; i++) cycle(1'b1, 1 + int'($urandom % 63), 0, 1'b0);
    chk("reclaim_preg", bus.alloc_preg, 5);

    // Rollback of two uncommitted renames, then a full restore walk.
    do_reset();
    cycle(1'b1, 5, 0, 1'b0);
    cycle(1'b1, 6, 0, 1'b0);
    cycle(1'b1, 7, 0, 1'b0);
    cycle(1'b0, 0, 1, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      chk("rb_beat_A", bus.restore_A_rd, i);
      chk("rb_beat_P", bus.restore_P_rd, (i == 5) ? 64 : i);
      cycle(1'b1, 1, 0, 1'b0);
    end
    chk("rb_busy_len", busy_cnt, 64);
    chk("rb_busy_end", bus.busy, 0);
    chk("rb_next_preg", bus.alloc_preg, 65);
    chk("rb_free_count", bus.free_count, 64);

    // Reset in the middle of a restore walk.
    cycle(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 1'b0);
    chk("rst_beat_A", bus.restore_A_rd, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk_reset_state("midrst");
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b0);

    // Wrap: 200 renames cycling through x1..x31.
    do_reset();
    issued = 0; committed = 0; guard = 0;
    while (committed < 200 && guard < 3000) begin
      req = (issued < 200) && ($urandom % 4 != 0);
      cm  = (infl.size() > 0 && $urandom % 3 != 0) ? 1 : 0;
      if (cm == 1) committed++;
      cycle(req, 1 + (issued % 31), cm, 1'b0);
      if (last_grant) issued++;
      guard++;
    end
    chk("wrap_done", committed, 200);
    chk("wrap_count", bus.free_count, 64);

    // Random mix including recoveries and no-effect commits.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      cm = (infl.size() > 0 && $urandom % 2 == 1) ? 1 : (($urandom % 25 == 0) ? 2 : 0);
      cycle($urandom % 3 != 0, 1 + int'($urandom % 63), cm, ($urandom % 100) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
